// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared types and widths for the fan speed controller
package fan_pkg;

  typedef enum logic [1:0] {IDLE, KICK, RUN, FAULT} fan_state_t;

  localparam int          FAN_USPR_W   = 20;
  localparam logic [19:0] FAN_USPR_SAT = 20'hFFFFF;
  localparam int          FAN_PCT_W    = 8;
  localparam logic [7:0]  FAN_PCT_MAX  = 8'hFF;
  localparam int          FAN_MS_W     = 16;

endpackage

// File: rtl/fan_ms_timer.sv
// rtl/fan_ms_timer.sv - loadable down-counter of 1 ms strobes
module fan_ms_timer
  import fan_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tsc_1ppms,
  input  logic                load,
  input  logic [FAN_MS_W-1:0] load_val,
  output logic                expire
);

  logic [FAN_MS_W-1:0] cnt;

  // Fires on the strobe that takes the count from 1 to 0.
  assign expire = tsc_1ppms && (cnt == FAN_MS_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tsc_1ppms && (cnt != '0)) begin
      cnt <= cnt - FAN_MS_W'(1);
    end
  end

endmodule

// File: rtl/fan_ctrl.sv
// rtl/fan_ctrl.sv - closed-loop fan duty regulator with kick-start and stall fault
module fan_ctrl
  import fan_pkg::*;
#(
  parameter int                    UPDATE_MS   = 100,
  parameter int                    KICK_MS     = 500,
  parameter logic [FAN_PCT_W-1:0]  STEP        = 8'd2,
  parameter logic [FAN_USPR_W-1:0] DEADBAND_US = 20'd32,
  parameter logic [FAN_PCT_W-1:0]  PCT_MIN     = 8'h40,
  parameter logic [FAN_PCT_W-1:0]  PCT_START   = 8'h80,
  parameter int                    STALL_UPD   = 3,
  parameter int                    RETRIES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tsc_1ppms,
  input  logic                  enable,
  input  logic [FAN_USPR_W-1:0] target_uspr,
  input  logic [FAN_USPR_W-1:0] fan_uspr,
  output logic [FAN_PCT_W-1:0]  fan_pct,
  output logic                  fan_locked,
  output logic                  fan_stall
);

  localparam int SC_W = $clog2(STALL_UPD + 1);
  localparam int RC_W = $clog2(RETRIES + 2);

  fan_state_t           state, state_d;
  logic [FAN_PCT_W-1:0] pct_d, pct_up, pct_dn;
  logic                 locked_d, stall_d;
  logic [SC_W-1:0]      stall_cnt, stall_cnt_d, stall_nxt;
  logic [RC_W-1:0]      retry_cnt, retry_d;
  logic                 tmr_load, tmr_expire;
  logic [FAN_MS_W-1:0]  tmr_val;
  logic [FAN_USPR_W:0]  band_hi, band_lo, meas;
  logic                 sat, too_slow, too_fast;

  fan_ms_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tsc_1ppms (tsc_1ppms),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expire    (tmr_expire)
  );

  // Band limits in 21 bits so target+deadband cannot wrap.
  always_comb begin
    meas     = {1'b0, fan_uspr};
    sat      = (fan_uspr == FAN_USPR_SAT);
    band_hi  = {1'b0, target_uspr} + {1'b0, DEADBAND_US};
    band_lo  = (target_uspr >= DEADBAND_US) ? {1'b0, target_uspr - DEADBAND_US} : '0;
    too_slow = sat || (meas > band_hi);
    too_fast = !sat && (meas < band_lo);
    stall_nxt = sat ? stall_cnt + SC_W'(1) : '0;
    pct_up   = (({1'b0, fan_pct} + {1'b0, STEP}) > 9'h0FF) ? FAN_PCT_MAX : fan_pct + STEP;
    pct_dn   = ({1'b0, fan_pct} < ({1'b0, PCT_MIN} + {1'b0, STEP})) ? PCT_MIN : fan_pct - STEP;
  end

  always_comb begin
    state_d     = state;
    pct_d       = fan_pct;
    locked_d    = fan_locked;
    stall_d     = fan_stall;
    stall_cnt_d = stall_cnt;
    retry_d     = retry_cnt;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    if (!enable) begin
      state_d     = IDLE;
      pct_d       = '0;
      locked_d    = 1'b0;
      stall_d     = 1'b0;
      stall_cnt_d = '0;
      retry_d     = '0;
      tmr_load    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_d  = KICK;
          pct_d    = FAN_PCT_MAX;
          locked_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = FAN_MS_W'(KICK_MS);
        end
        KICK: begin
          if (tmr_expire) begin
            state_d     = RUN;
            pct_d       = PCT_START;
            stall_cnt_d = '0;
            tmr_load    = 1'b1;
            tmr_val     = FAN_MS_W'(UPDATE_MS);
          end
        end
        RUN: begin
          if (tmr_expire) begin
            tmr_load    = 1'b1;
            tmr_val     = FAN_MS_W'(UPDATE_MS);
            stall_cnt_d = stall_nxt;
            if (stall_nxt == SC_W'(STALL_UPD)) begin
              pct_d    = FAN_PCT_MAX;
              locked_d = 1'b0;
              if (retry_cnt < RC_W'(RETRIES)) begin
                retry_d = retry_cnt + RC_W'(1);
                state_d = KICK;
                tmr_val = FAN_MS_W'(KICK_MS);
              end else begin
                state_d = FAULT;
                stall_d = 1'b1;
              end
            end else begin
              locked_d = !too_slow && !too_fast;
              if (too_slow)      pct_d = pct_up;
              else if (too_fast) pct_d = pct_dn;
              else               retry_d = '0;
            end
          end
        end
        FAULT: begin
          pct_d    = FAN_PCT_MAX;
          stall_d  = 1'b1;
          locked_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fan_pct    <= '0;
      fan_locked <= 1'b0;
      fan_stall  <= 1'b0;
      stall_cnt  <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_d;
      fan_pct    <= pct_d;
      fan_locked <= locked_d;
      fan_stall  <= stall_d;
      stall_cnt  <= stall_cnt_d;
      retry_cnt  <= retry_d;
    end
  end

endmodule
